// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: accepts one instruction per handshake and sequences
// the datapath through DECODE, EXEC, MEM and WB, driving its control ports.
module control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [3:0]  ALUop,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE} class_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t      state, state_next;
    logic [31:0] instr_q;
    logic        alusrc_r, memtoreg_r, rd_nz_r;
    logic [3:0]  aluop_r;
    class_t      class_r;

    logic        dec_legal, dec_alusrc, dec_memtoreg;
    logic [3:0]  dec_aluop;
    class_t      dec_class;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        unused_fields;

    assign opcode        = instr_q[6:0];
    assign funct3        = instr_q[14:12];
    assign funct7        = instr_q[31:25];
    // rs1/rs2 belong to the datapath; only opcode, funct and rd matter for control.
    assign unused_fields = ^instr_q[24:15];

    // Shared funct3 -> ALU function map for R-type and I-type ALU instructions.
    function automatic logic [3:0] alu_for_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            3'b111:  return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec_legal    = 1'b0;
        dec_alusrc   = 1'b0;
        dec_aluop    = OP_ADD;
        dec_memtoreg = 1'b0;
        dec_class    = C_ALU;
        case (opcode)
            OPC_R: begin
                if (funct7 == 7'b0000000 && funct3 != 3'b011) begin
                    dec_legal = 1'b1;
                    dec_aluop = alu_for_funct3(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_aluop = OP_SUB;
                end
            end
            OPC_I: begin
                dec_alusrc = 1'b1;
                dec_aluop  = alu_for_funct3(funct3);
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_legal = (funct7 == 7'b0000000);
                else
                    dec_legal = (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                dec_legal    = (funct3 == 3'b010);
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_class    = C_LOAD;
            end
            OPC_STORE: begin
                dec_legal  = (funct3 == 3'b010);
                dec_alusrc = 1'b1;
                dec_class  = C_STORE;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            instr_q    <= '0;
            alusrc_r   <= 1'b0;
            aluop_r    <= OP_AND;
            memtoreg_r <= 1'b0;
            class_r    <= C_ALU;
            rd_nz_r    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && instr_valid)
                instr_q <= instruction;
            // Illegal words leave the previous control settings on the datapath.
            if (state == S_DECODE && dec_legal) begin
                alusrc_r   <= dec_alusrc;
                aluop_r    <= dec_aluop;
                memtoreg_r <= dec_memtoreg;
                class_r    <= dec_class;
                rd_nz_r    <= (instr_q[11:7] != 5'd0);
            end
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_next = S_EXEC;
                end else begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                state_next = (class_r == C_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (class_r == C_STORE) begin
                    MemWrite   = 1'b1;
                    done       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    MemRead    = 1'b1;
                    state_next = S_WB;
                end
            end
            S_WB: begin
                RegWrite   = rd_nz_r;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ALUSrc   = alusrc_r;
    assign ALUop    = aluop_r;
    assign MemtoReg = memtoreg_r;

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm: per-instruction expected control
// values with a cycle-accurate strobe schedule, plus a mid-instruction reset sequence.
module tb_control_fsm;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_ILL} kind_t;
    typedef struct {
        logic [31:0] instr;
        kind_t       kind;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        memtoreg;
        logic        regw;
    } vec_t;

    logic        clk, rst, instr_valid;
    logic [31:0] instruction;
    logic        instr_ready, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, done, illegal;
    logic [3:0]  ALUop;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] prev_aluop;
    logic       prev_alusrc, prev_memtoreg;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .ALUop       (ALUop),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemtoReg    (MemtoReg),
        .done        (done),
        .illegal     (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " instr_ready"}, instr_ready, 1);
        check({tag, " RegWrite"},    RegWrite,    0);
        check({tag, " ALUSrc"},      ALUSrc,      0);
        check({tag, " ALUop"},       ALUop,       0);
        check({tag, " MemWrite"},    MemWrite,    0);
        check({tag, " MemRead"},     MemRead,     0);
        check({tag, " MemtoReg"},    MemtoReg,    0);
        check({tag, " done"},        done,        0);
        check({tag, " illegal"},     illegal,     0);
    endtask

    // Expected outputs in cycle c of an instruction of length len (cycle 0 = handshake).
    task automatic check_cycle(input vec_t v, input int idx, input int c, input int len);
        string      tag;
        logic       regs_new;
        logic [3:0] e_aluop;
        logic       e_alusrc, e_memtoreg;
        tag        = $sformatf("v%0d c%0d", idx, c);
        regs_new   = (v.kind != K_ILL) && (c >= 2);
        e_aluop    = regs_new ? v.aluop    : prev_aluop;
        e_alusrc   = regs_new ? v.alusrc   : prev_alusrc;
        e_memtoreg = regs_new ? v.memtoreg : prev_memtoreg;
        check({tag, " instr_ready"}, instr_ready, c == 0);
        check({tag, " RegWrite"},    RegWrite,
              (c == len - 1) && (v.kind == K_ALU || v.kind == K_LOAD) && v.regw);
        check({tag, " MemRead"},     MemRead,  (v.kind == K_LOAD)  && c == 3);
        check({tag, " MemWrite"},    MemWrite, (v.kind == K_STORE) && c == 3);
        check({tag, " done"},        done,     (c == len - 1) && c != 0);
        check({tag, " illegal"},     illegal,  (v.kind == K_ILL)   && c == 1);
        check({tag, " ALUop"},       ALUop,    e_aluop);
        check({tag, " ALUSrc"},      ALUSrc,   e_alusrc);
        check({tag, " MemtoReg"},    MemtoReg, e_memtoreg);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int len;
        case (v.kind)
            K_LOAD:  len = 5;
            K_ILL:   len = 2;
            default: len = 4;
        endcase
        for (int c = 0; c < len; c++) begin
            check_cycle(v, idx, c, len);
            if (c == 0) begin
                instr_valid = 1'b1;
                instruction = v.instr;
            end else if (c < len - 1) begin
                // Junk offered while busy must be ignored.
                instr_valid = 1'b1;
                instruction = $urandom;
            end else begin
                instr_valid = 1'b0;
                instruction = '0;
            end
            @(negedge clk);
        end
        if (v.kind != K_ILL) begin
            prev_aluop    = v.aluop;
            prev_alusrc   = v.alusrc;
            prev_memtoreg = v.memtoreg;
        end
    endtask

    initial begin
        vecs[0]  = '{32'h00108433, K_ALU,   4'b0010, 1'b0, 1'b0, 1'b1}; // add x8,x1,x1
        vecs[1]  = '{32'h402081B3, K_ALU,   4'b0110, 1'b0, 1'b0, 1'b1}; // sub x3,x1,x2
        vecs[2]  = '{32'h00812283, K_LOAD,  4'b0010, 1'b1, 1'b1, 1'b1}; // lw x5,8(x2)
        vecs[3]  = '{32'h00512223, K_STORE, 4'b0010, 1'b1, 1'b0, 1'b0}; // sw x5,4(x2)
        vecs[4]  = '{32'h00000013, K_ALU,   4'b0010, 1'b1, 1'b0, 1'b0}; // addi x0,x0,0
        vecs[5]  = '{32'hFFFFFFFF, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h4000D433, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // sra
        vecs[7]  = '{32'h003140B3, K_ALU,   4'b0011, 1'b0, 1'b0, 1'b1}; // xor x1,x2,x3
        vecs[8]  = '{32'h00309093, K_ALU,   4'b0100, 1'b1, 1'b0, 1'b1}; // slli x1,x1,3
        vecs[9]  = '{32'h0030D093, K_ALU,   4'b0101, 1'b1, 1'b0, 1'b1}; // srli x1,x1,3
        vecs[10] = '{32'h4030D093, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // srai
        vecs[11] = '{32'h003130B3, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // sltu
        vecs[12] = '{32'h003120B3, K_ALU,   4'b0111, 1'b0, 1'b0, 1'b1}; // slt x1,x2,x3
        vecs[13] = '{32'h00517093, K_ALU,   4'b0000, 1'b1, 1'b0, 1'b1}; // andi x1,x2,5
        vecs[14] = '{32'h003160B3, K_ALU,   4'b0001, 1'b0, 1'b0, 1'b1}; // or x1,x2,x3
        vecs[15] = '{32'h00810283, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // lb
        vecs[16] = '{32'h00000063, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // beq
        vecs[17] = '{32'h00000000, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{32'h023100B3, K_ILL,   4'b0000, 1'b0, 1'b0, 1'b0}; // mul
        vecs[19] = '{32'h00012003, K_LOAD,  4'b0010, 1'b1, 1'b1, 1'b0}; // lw x0,0(x2)

        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        prev_aluop    = 4'b0000;
        prev_alusrc   = 1'b0;
        prev_memtoreg = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_vec(vecs[i], i);

        // lw aborted by reset early in its MEM cycle.
        check("abort c0 instr_ready", instr_ready, 1);
        instr_valid = 1'b1;
        instruction = 32'h00812283;
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = '0;
        @(negedge clk);
        check("abort c2 ALUop", ALUop, 4'b0010);
        check("abort c2 MemRead", MemRead, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("abort hold%0d", k));
        end
        rst = 1'b0;
        prev_aluop    = 4'b0000;
        prev_alusrc   = 1'b0;
        prev_memtoreg = 1'b0;
        run_vec(vecs[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
